// File: rtl/sa_tile_sequencer_if.sv
// Command and SRAM-control bundle for sa_tile_sequencer.
// The master side is the host that drives the commands. The slave side is the sequencer.
interface sa_tile_sequencer_if #(
    parameter int NUM_ROW              = 4,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int K_WIDTH              = 8,
    parameter int CTRL_WIDTH           = 4
);
    localparam int ROW_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

    // Handshake: i_start is a one-cycle request and is honoured only while o_busy is low.
    // On acceptance, i_k_len and the three bases are captured. Every accepted request ends
    // with exactly one o_done pulse, except when the pass is cut short by i_abort or reset.
    logic                            i_start;
    logic                            i_abort;
    logic [K_WIDTH-1:0]              i_k_len;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_base;
    logic [CTRL_WIDTH-1:0]           o_ctrl_state;
    logic                            o_acc_clr;
    logic                            o_top_rd_en;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_addr;
    logic                            o_left_rd_en;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_addr;
    logic                            o_down_wr_en;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_wr_addr;
    logic [ROW_W-1:0]                o_row_sel;
    logic                            o_busy;
    logic                            o_done;

    modport master (
        output i_start, i_abort, i_k_len, i_top_base, i_left_base, i_down_base,
        input  o_ctrl_state, o_acc_clr, o_top_rd_en, o_top_rd_addr, o_left_rd_en,
               o_left_rd_addr, o_down_wr_en, o_down_wr_addr, o_row_sel, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_k_len, i_top_base, i_left_base, i_down_base,
        output o_ctrl_state, o_acc_clr, o_top_rd_en, o_top_rd_addr, o_left_rd_en,
               o_left_rd_addr, o_down_wr_en, o_down_wr_addr, o_row_sel, o_busy, o_done
    );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Tile-pass controller for the systolic array.
// A pass runs clear, K-deep operand streaming, skew drain, then row-by-row writeback.
module sa_tile_sequencer #(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int K_WIDTH              = 8,
    parameter int CTRL_WIDTH           = 4,
    parameter int SRAM_RD_LAT          = 1
) (
    input logic                clk,
    input logic                rst_n,
    sa_tile_sequencer_if.slave ctrl
);
    localparam int AW        = LOG2_SRAM_BANK_DEPTH;
    localparam int ROW_W     = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam int DRAIN_LEN = NUM_ROW + NUM_COL - 1 + SRAM_RD_LAT;
    localparam int PHASE_W   = $clog2(DRAIN_LEN + NUM_ROW + 1);
    localparam int CNT_W0    = (K_WIDTH > PHASE_W) ? K_WIDTH : PHASE_W;
    localparam int CNT_W     = (CNT_W0 > AW) ? CNT_W0 : AW;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(NUM_ROW - 1);

    typedef enum logic [CTRL_WIDTH-1:0] {
        S_IDLE,
        S_WARMUP,
        S_STEADY,
        S_DRAIN,
        S_WB
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [K_WIDTH-1:0] k_q, k_d;
    logic [AW-1:0]      top_base_q, top_base_d;
    logic [AW-1:0]      left_base_q, left_base_d;
    logic [AW-1:0]      down_base_q, down_base_d;
    logic [CNT_W-1:0]   k_last;
    logic               done_d;

    logic               acc_clr, top_rd_en, left_rd_en, down_wr_en, busy, done;
    logic [AW-1:0]      top_rd_addr, left_rd_addr, down_wr_addr;
    logic [ROW_W-1:0]   row_sel;

    assign k_last = CNT_W'(k_q) - CNT_W'(1);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        k_d         = k_q;
        top_base_d  = top_base_q;
        left_base_d = left_base_q;
        down_base_d = down_base_q;
        done_d      = 1'b0;
        if (state != S_IDLE && ctrl.i_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Abort wins over a simultaneous start.
                    if (ctrl.i_start && !ctrl.i_abort) begin
                        k_d         = ctrl.i_k_len;
                        top_base_d  = ctrl.i_top_base;
                        left_base_d = ctrl.i_left_base;
                        down_base_d = ctrl.i_down_base;
                        cnt_d       = '0;
                        if (ctrl.i_k_len == '0) done_d  = 1'b1;
                        else                    state_d = S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    state_d = S_STEADY;
                    cnt_d   = '0;
                end
                S_STEADY: begin
                    if (cnt == k_last) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state_d = S_WB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                S_WB: begin
                    if (cnt == WB_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            k_q          <= '0;
            top_base_q   <= '0;
            left_base_q  <= '0;
            down_base_q  <= '0;
            acc_clr      <= 1'b0;
            top_rd_en    <= 1'b0;
            left_rd_en   <= 1'b0;
            down_wr_en   <= 1'b0;
            top_rd_addr  <= '0;
            left_rd_addr <= '0;
            down_wr_addr <= '0;
            row_sel      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            k_q         <= k_d;
            top_base_q  <= top_base_d;
            left_base_q <= left_base_d;
            down_base_q <= down_base_d;
            acc_clr     <= (state_d == S_WARMUP);
            top_rd_en   <= (state_d == S_STEADY);
            left_rd_en  <= (state_d == S_STEADY);
            down_wr_en  <= (state_d == S_WB);
            busy        <= (state_d != S_IDLE);
            done        <= done_d;
            // Addresses hold their last value outside the phase that drives them.
            // Truncating the counter gives the modulo-depth wrap.
            if (state_d == S_STEADY) begin
                top_rd_addr  <= top_base_q + cnt_d[AW-1:0];
                left_rd_addr <= left_base_q + cnt_d[AW-1:0];
            end
            if (state_d == S_WB) begin
                down_wr_addr <= down_base_q + cnt_d[AW-1:0];
                row_sel      <= cnt_d[ROW_W-1:0];
            end
        end
    end

    assign ctrl.o_ctrl_state   = state;
    assign ctrl.o_acc_clr      = acc_clr;
    assign ctrl.o_top_rd_en    = top_rd_en;
    assign ctrl.o_top_rd_addr  = top_rd_addr;
    assign ctrl.o_left_rd_en   = left_rd_en;
    assign ctrl.o_left_rd_addr = left_rd_addr;
    assign ctrl.o_down_wr_en   = down_wr_en;
    assign ctrl.o_down_wr_addr = down_wr_addr;
    assign ctrl.o_row_sel      = row_sel;
    assign ctrl.o_busy         = busy;
    assign ctrl.o_done         = done;
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Bench for sa_tile_sequencer: a pass-timeline reference model fills an expected queue,
// and each cycle the full output vector is compared against the next queued entry.
module tb_sa_tile_sequencer;
    localparam int NUM_ROW     = 4;
    localparam int NUM_COL     = 4;
    localparam int AW          = 5;
    localparam int K_WIDTH     = 8;
    localparam int CTRL_WIDTH  = 4;
    localparam int SRAM_RD_LAT = 1;
    localparam int ROW_W       = 2;
    localparam int D           = NUM_ROW + NUM_COL - 1 + SRAM_RD_LAT;
    localparam int VW          = CTRL_WIDTH + 2 + AW + 1 + AW + 1 + AW + ROW_W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_tile_sequencer_if #(.NUM_ROW(NUM_ROW), .LOG2_SRAM_BANK_DEPTH(AW),
                           .K_WIDTH(K_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) ctrl ();

    sa_tile_sequencer #(.NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .LOG2_SRAM_BANK_DEPTH(AW),
                        .K_WIDTH(K_WIDTH), .CTRL_WIDTH(CTRL_WIDTH),
                        .SRAM_RD_LAT(SRAM_RD_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (ctrl)
    );

    int checks = 0;
    int errors = 0;
    logic [VW-1:0] exp_q[$];

    // Model memory: last address/row values, which the outputs hold between phases.
    logic [AW-1:0]    m_top = '0, m_left = '0, m_down = '0;
    logic [ROW_W-1:0] m_row = '0;

    function automatic logic [VW-1:0] pack(logic [CTRL_WIDTH-1:0] st, logic clr,
                                           logic te, logic [AW-1:0] ta,
                                           logic le, logic [AW-1:0] la,
                                           logic de, logic [AW-1:0] da,
                                           logic [ROW_W-1:0] rs, logic bsy, logic dn);
        return {st, clr, te, ta, le, la, de, da, rs, bsy, dn};
    endfunction

    function automatic logic [VW-1:0] observed();
        return pack(ctrl.o_ctrl_state, ctrl.o_acc_clr, ctrl.o_top_rd_en, ctrl.o_top_rd_addr,
                    ctrl.o_left_rd_en, ctrl.o_left_rd_addr, ctrl.o_down_wr_en,
                    ctrl.o_down_wr_addr, ctrl.o_row_sel, ctrl.o_busy, ctrl.o_done);
    endfunction

    // Queues the expected outputs for cycles t = 1.. after a start in cycle 0.
    // If kill_t is nonzero, an abort (or a reset) is applied during cycle kill_t.
    task automatic model_pass(int k, int tb, int lb, int db, int kill_t, bit kill_rst);
        int total;
        int r;
        if (k == 0) begin
            exp_q.push_back(pack(0, 0, 0, m_top, 0, m_left, 0, m_down, m_row, 0, 1));
            return;
        end
        total = 2 + k + D + NUM_ROW;
        for (int t = 1; t <= total; t++) begin
            if (kill_t != 0 && t == kill_t + 1) begin
                if (kill_rst) begin
                    m_top = '0; m_left = '0; m_down = '0; m_row = '0;
                end
                exp_q.push_back(pack(0, 0, 0, m_top, 0, m_left, 0, m_down, m_row, 0, 0));
                return;
            end
            if (t == 1) begin
                exp_q.push_back(pack(1, 1, 0, m_top, 0, m_left, 0, m_down, m_row, 1, 0));
            end else if (t <= k + 1) begin
                m_top  = AW'(tb + t - 2);
                m_left = AW'(lb + t - 2);
                exp_q.push_back(pack(2, 0, 1, m_top, 1, m_left, 0, m_down, m_row, 1, 0));
            end else if (t <= k + 1 + D) begin
                exp_q.push_back(pack(3, 0, 0, m_top, 0, m_left, 0, m_down, m_row, 1, 0));
            end else if (t < total) begin
                r      = t - (k + 2 + D);
                m_down = AW'(db + r);
                m_row  = ROW_W'(r);
                exp_q.push_back(pack(4, 0, 0, m_top, 0, m_left, 1, m_down, m_row, 1, 0));
            end else begin
                exp_q.push_back(pack(0, 0, 0, m_top, 0, m_left, 0, m_down, m_row, 0, 1));
            end
        end
    endtask

    // Called at a negedge. Drives start this cycle, then checks every queued cycle.
    // It returns at the negedge of the final expected cycle.
    task automatic run_pass(string name, int k, int tb, int lb, int db,
                            int kill_t, bit kill_rst, int busy_t);
        int n;
        logic [VW-1:0] got, exp;
        model_pass(k, tb, lb, db, kill_t, kill_rst);
        n = exp_q.size();
        ctrl.i_start     = 1'b1;
        ctrl.i_k_len     = K_WIDTH'(k);
        ctrl.i_top_base  = AW'(tb);
        ctrl.i_left_base = AW'(lb);
        ctrl.i_down_base = AW'(db);
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            ctrl.i_start = 1'b0;
            ctrl.i_abort = 1'b0;
            rst_n        = 1'b1;
            got = observed();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s t=%0d got=%h expected=%h", name, t, got, exp);
            end
            if (t == busy_t) begin
                ctrl.i_start     = 1'b1;
                ctrl.i_k_len     = K_WIDTH'(k + 3);
                ctrl.i_top_base  = AW'(tb + 7);
                ctrl.i_left_base = AW'(lb + 9);
                ctrl.i_down_base = AW'(db + 11);
            end
            if (t == kill_t) begin
                if (kill_rst) rst_n = 1'b0;
                else          ctrl.i_abort = 1'b1;
            end
        end
    endtask

    // Idle cycles. mode 1 pulses abort alone; mode 2 pulses abort together with start.
    task automatic test_idle(string name, int n, int mode);
        logic [VW-1:0] got, exp;
        for (int i = 0; i < n; i++) begin
            ctrl.i_abort = (mode != 0);
            ctrl.i_start = (mode == 2);
            ctrl.i_k_len = 8'd3;
            @(negedge clk);
            ctrl.i_abort = 1'b0;
            ctrl.i_start = 1'b0;
            exp = pack(0, 0, 0, m_top, 0, m_left, 0, m_down, m_row, 0, 0);
            got = observed();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s i=%0d got=%h expected=%h", name, i, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = observed();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset got=%h expected=0", got);
        end
        rst_n = 1'b1;
        test_idle("reset_idle", 5, 0);
    endtask

    task automatic test_nominal();
        run_pass("nominal", 4, 0, 0, 0, 0, 0, 0);
        test_idle("nominal_after", 2, 0);
    endtask

    task automatic test_wrap();
        run_pass("wrap", 5, 30, 2, 30, 0, 0, 0);
        test_idle("wrap_after", 1, 0);
    endtask

    task automatic test_k_zero();
        run_pass("k_zero", 0, 9, 10, 11, 0, 0, 0);
        test_idle("k_zero_after", 3, 0);
    endtask

    task automatic test_abort();
        run_pass("abort", 8, 3, 4, 5, 4, 0, 0);
        test_idle("abort_after", 2, 0);
        run_pass("after_abort", 2, 1, 2, 3, 0, 0, 0);
        test_idle("abort_in_idle", 2, 1);
        test_idle("abort_with_start", 2, 2);
    endtask

    task automatic test_busy_start();
        run_pass("busy_start", 6, 12, 20, 8, 0, 0, 4);
        test_idle("busy_after", 1, 0);
    endtask

    task automatic test_back_to_back();
        run_pass("b2b_first", 3, 5, 6, 7, 0, 0, 0);
        run_pass("b2b_second", 2, 28, 29, 31, 0, 0, 0);
        test_idle("b2b_after", 1, 0);
    endtask

    task automatic test_reset_mid();
        run_pass("reset_mid", 3, 17, 18, 19, 3, 1, 0);
        test_idle("reset_mid_after", 2, 0);
    endtask

    task automatic test_random();
        int k, kill_t;
        for (int i = 0; i < 10; i++) begin
            k = $urandom_range(0, 10);
            kill_t = 0;
            if (k > 0 && $urandom_range(0, 2) == 0)
                kill_t = $urandom_range(1, 1 + k + D + NUM_ROW);
            run_pass("random", k, $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), kill_t, 1'b0,
                     (k > 2) ? $urandom_range(2, k + 1) : 0);
            if ($urandom_range(0, 1) == 1) test_idle("random_gap", 1, 0);
        end
    endtask

    initial begin
        ctrl.i_start     = 1'b0;
        ctrl.i_abort     = 1'b0;
        ctrl.i_k_len     = '0;
        ctrl.i_top_base  = '0;
        ctrl.i_left_base = '0;
        ctrl.i_down_base = '0;
        test_reset();
        test_nominal();
        test_wrap();
        test_k_zero();
        test_abort();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
- Autonomous controller for systolic_array_top. Replaces bench-driven i_ctrl_state and address sequencing.
- On a start pulse, runs one output-stationary tile pass: accumulator clear, K-deep streaming of the top and left SRAMs, skew drain, then row-by-row writeback into the down SRAM.
- Generalised in array size, reduction depth, SRAM read latency and buffer base addresses. Supports abort and a done handshake.

Parameters:
- NUM_ROW, 4, array rows
- NUM_COL, 4, array columns
- LOG2_SRAM_BANK_DEPTH, 5, SRAM address width
- K_WIDTH, 8, width of the reduction-length field
- CTRL_WIDTH, 4, width of o_ctrl_state
- SRAM_RD_LAT, 1, top/left SRAM read latency in cycles (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_abort  in  1  abort current pass
- i_k_len  in  K_WIDTH  reduction length K; latched at start
- i_top_base  in  LOG2_SRAM_BANK_DEPTH  top SRAM start address; latched at start
- i_left_base  in  LOG2_SRAM_BANK_DEPTH  left SRAM start address; latched at start
- i_down_base  in  LOG2_SRAM_BANK_DEPTH  down SRAM start address; latched at start
- o_ctrl_state  out  CTRL_WIDTH  array state: IDLE=0, WARMUP=1, STEADY=2, DRAIN=3, WRITEBACK=4
- o_acc_clr  out  1  clear PE accumulators
- o_top_rd_en  out  1  top SRAM read enable
- o_top_rd_addr  out  LOG2_SRAM_BANK_DEPTH  top SRAM read address
- o_left_rd_en  out  1  left SRAM read enable
- o_left_rd_addr  out  LOG2_SRAM_BANK_DEPTH  left SRAM read address
- o_down_wr_en  out  1  down SRAM write enable
- o_down_wr_addr  out  LOG2_SRAM_BANK_DEPTH  down SRAM write address
- o_row_sel  out  $clog2(NUM_ROW)  array row muxed onto the down write bus
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: o_ctrl_state=IDLE(0); all enables, o_acc_clr, o_busy and o_done = 0; all addresses and o_row_sel = 0; internal counters = 0.
- Reset mid-pass has the same effect: IDLE next edge, no o_done.
- All outputs are registered.
- IDLE:
  - i_start=1 latches K and the three base addresses.
  - K≥1: go to WARMUP. K=0: stay IDLE and pulse o_done in the next cycle; no reads, no writes.
- WARMUP: exactly 1 cycle with o_acc_clr=1, then STEADY.
- STEADY: K cycles, counter k=0..K-1.
  - o_top_rd_en = o_left_rd_en = 1.
  - o_top_rd_addr = top_base+k and o_left_rd_addr = left_base+k, both modulo 2^LOG2_SRAM_BANK_DEPTH (wrap, no error).
  - After k=K-1, go to DRAIN.
- DRAIN: D = NUM_ROW+NUM_COL-1+SRAM_RD_LAT cycles. Read enables 0; addresses hold their last value. Then WRITEBACK.
- WRITEBACK: NUM_ROW cycles, r=0..NUM_ROW-1.
  - o_down_wr_en=1, o_down_wr_addr=down_base+r (wrapping), o_row_sel=r.
  - Then IDLE with o_done=1 for that first IDLE cycle.
- Latency: if i_start is high in cycle c0, o_done is high in cycle c0+2+K+D+NUM_ROW. With defaults and K=4 that is c0+18.
- i_start while busy: ignored; latched values are unchanged.
- i_start in the o_done cycle: accepted (state is IDLE); the new pass begins in the next cycle.
- i_abort:
  - In any non-IDLE state: IDLE next edge, all enables 0, no o_done; partial down writes already issued stay written.
  - i_abort in IDLE: no effect. i_abort and i_start together in IDLE: abort wins, stay IDLE.
- o_busy = (o_ctrl_state != IDLE).

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then 1 → o_ctrl_state=0, all enables 0, o_done never asserts without i_start.
- Nominal pass: K=4, bases 0/0/0, start in cycle c0.
  - c1: WARMUP with o_acc_clr=1.
  - c2..c5: STEADY, read addresses 0,1,2,3.
  - c6..c13: DRAIN.
  - c14..c17: WRITEBACK, down addresses 0..3, row_sel 0..3.
  - c18: o_done=1.
- Wrap: K=5, top_base=30, left_base=2, down_base=30 → top addresses 30,31,0,1,2; left addresses 2..6; down addresses 30,31,0,1.
- K=0: start → o_done in the next cycle; no read or write enable is ever asserted; o_busy stays 0.
- Abort: K=8, assert i_abort in the 3rd STEADY cycle → IDLE next edge, enables 0, no o_done. A following start with K=2 completes in 2+2+8+4=16 cycles.
- Busy start / back-to-back: pulse i_start with new bases mid-STEADY → addresses are unchanged. Restart in the o_done cycle → WARMUP in the next cycle.
